// File: rtl/alu_pkg.sv
// Shared op encodings, datapath width and small decode helpers for the execute-stage ALU.
// Pure declarations; no logic, latency or flow control of its own.
package alu_pkg;

  localparam int WIDTH = 32;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND = 3'b000;
  localparam op_t OP_OR  = 3'b001;
  localparam op_t OP_ADD = 3'b010;
  localparam op_t OP_RSV = 3'b011;
  localparam op_t OP_NOR = 3'b100;
  localparam op_t OP_XOR = 3'b101;
  localparam op_t OP_SUB = 3'b110;
  localparam op_t OP_SLT = 3'b111;

  function automatic logic is_addsub(input op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: a + b, or a - b as a + ~b + 1, with carry-out and signed overflow.
// Combinational, zero latency; no backpressure.
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;

  assign w_b_eff   = sub ? ~b : b;
  assign w_sum     = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, sub};
  assign result    = w_sum[WIDTH-1:0];
  assign carry_out = w_sum[WIDTH];

  // Same-sign operands into the adder producing an opposite-sign result.
  assign overflow  = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// MIPS-style execute ALU: add/sub, logic ops, set-less-than, plus a sticky signed-overflow flag.
// Result/compare/overflow combinational (0 cycles); ovf_sticky one clock edge later. No backpressure.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             unsig,
  output logic [WIDTH-1:0] aluout,
  output logic             compout,
  output logic             overflow,
  output logic             ovf_sticky
);

  logic [WIDTH-1:0] w_arith_res;
  logic             w_arith_cout;
  logic             w_arith_ovf;
  logic             w_arith_sub;
  logic [WIDTH-1:0] w_diff;
  logic             w_cmp_cout;
  logic             w_cmp_ovf;
  logic             w_unused;
  logic             r_ovf_sticky;

  assign w_arith_sub = (op == OP_SUB);

  alu_addsub #(.WIDTH(WIDTH)) u_arith (
    .a         (a),
    .b         (b),
    .sub       (w_arith_sub),
    .result    (w_arith_res),
    .carry_out (w_arith_cout),
    .overflow  (w_arith_ovf)
  );

  // Dedicated comparator so compout is valid regardless of the selected op.
  alu_addsub #(.WIDTH(WIDTH)) u_cmp (
    .a         (a),
    .b         (b),
    .sub       (1'b1),
    .result    (w_diff),
    .carry_out (w_cmp_cout),
    .overflow  (w_cmp_ovf)
  );

  assign w_unused = w_arith_cout;

  // No carry out of a + ~b + 1 means a borrow, i.e. unsigned a < b.
  assign compout  = unsig ? ~w_cmp_cout : (w_diff[WIDTH-1] ^ w_cmp_ovf);
  assign overflow = ~unsig & is_addsub(op) & w_arith_ovf;

  always_comb begin
    aluout = '0;
    case (op)
      OP_AND:  aluout = a & b;
      OP_OR:   aluout = a | b;
      OP_ADD:  aluout = w_arith_res;
      OP_RSV:  aluout = '0;
      OP_NOR:  aluout = ~(a | b);
      OP_XOR:  aluout = a ^ b;
      OP_SUB:  aluout = w_arith_res;
      OP_SLT:  aluout = {{(WIDTH-1){1'b0}}, compout};
      default: aluout = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf_sticky <= 1'b0;
    end else if (overflow) begin
      r_ovf_sticky <= 1'b1;
    end
  end

  assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, sticky/reset sequences, random vs. reference model.
module tb_alu;

  logic        clock;
  logic        reset_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        unsig;
  logic [31:0] aluout;
  logic        compout;
  logic        overflow;
  logic        ovf_sticky;

  int n_total;
  int n_pass;

  alu dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .a          (a),
    .b          (b),
    .op         (op),
    .unsig      (unsig),
    .aluout     (aluout),
    .compout    (compout),
    .overflow   (overflow),
    .ovf_sticky (ovf_sticky)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic        unsig;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_ovf;
    logic        chk_comp;
    logic        exp_comp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [2:0] vop, input logic vu, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] vout, input logic vovf,
                         input logic vchk, input logic vcomp);
    vec_t v;
    v.op = vop; v.unsig = vu; v.a = va; v.b = vb;
    v.exp_out = vout; v.exp_ovf = vovf; v.chk_comp = vchk; v.exp_comp = vcomp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model from the arithmetic definition, using 64-bit signed math.
  function automatic void model(input logic [2:0] mop, input logic mu, input logic [31:0] ma,
                                input logic [31:0] mb, output logic [31:0] r,
                                output logic c, output logic v);
    longint sa;
    longint sb;
    longint s;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    c  = mu ? (ma < mb) : (sa < sb);
    v  = 1'b0;
    r  = 32'h0;
    case (mop)
      3'd0: r = ma & mb;
      3'd1: r = ma | mb;
      3'd2: r = ma + mb;
      3'd3: r = 32'h0;
      3'd4: r = ~(ma | mb);
      3'd5: r = ma ^ mb;
      3'd6: r = ma - mb;
      3'd7: r = {31'b0, c};
      default: r = 32'h0;
    endcase
    if (!mu && (mop == 3'd2 || mop == 3'd6)) begin
      s = (mop == 3'd2) ? sa + sb : sa - sb;
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] edges [6];
    edges[0] = 32'h7FFFFFFF; edges[1] = 32'h80000000; edges[2] = 32'hFFFFFFFF;
    edges[3] = 32'h00000000; edges[4] = 32'h00000001; edges[5] = 32'hFFFFFF80;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  logic [31:0] m_out;
  logic        m_comp;
  logic        m_ovf;
  logic        m_sticky;

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset_n = 1'b0;
    a = 32'h7FFFFFFF; b = 32'h00000080; op = 3'b010; unsig = 1'b0;

    // Reset held low with an overflowing ADD: flag stays clear, datapath still live.
    @(negedge clock);
    #1;
    check("rst_sticky", {31'b0, ovf_sticky}, 32'h0);
    check("rst_aluout", aluout, 32'h8000007F);
    check("rst_ovf", {31'b0, overflow}, 32'h1);
    @(posedge clock); #1;
    check("rst_sticky_edge", {31'b0, ovf_sticky}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Signed overflow cases.
    add_vec(3'b010, 1'b0, 32'h7FFFFFFF, 32'h00000080, 32'h8000007F, 1'b1, 1'b0, 1'b0);
    add_vec(3'b010, 1'b0, 32'h80000008, 32'hFFFFFF80, 32'h7FFFFF88, 1'b1, 1'b0, 1'b0);
    add_vec(3'b110, 1'b0, 32'h7FFFFFFF, 32'hFFFFFF80, 32'h8000007F, 1'b1, 1'b0, 1'b0);
    add_vec(3'b110, 1'b0, 32'hFFFFFF80, 32'h7FFFFFFF, 32'h7FFFFF81, 1'b1, 1'b0, 1'b0);
    // No overflow.
    add_vec(3'b010, 1'b0, 32'h00000100, 32'h00000080, 32'h00000180, 1'b0, 1'b0, 1'b0);
    add_vec(3'b010, 1'b0, 32'hFFFFFF00, 32'hFFFFFF80, 32'hFFFFFE80, 1'b0, 1'b0, 1'b0);
    add_vec(3'b110, 1'b0, 32'h00000100, 32'hFFFFFF80, 32'h00000180, 1'b0, 1'b0, 1'b0);
    add_vec(3'b110, 1'b0, 32'hFFFFFF80, 32'h00000100, 32'hFFFFFE80, 1'b0, 1'b0, 1'b0);
    // Unsigned repeats: same result, never overflow.
    add_vec(3'b010, 1'b1, 32'h7FFFFFFF, 32'h00000080, 32'h8000007F, 1'b0, 1'b0, 1'b0);
    add_vec(3'b010, 1'b1, 32'h80000008, 32'hFFFFFF80, 32'h7FFFFF88, 1'b0, 1'b0, 1'b0);
    add_vec(3'b110, 1'b1, 32'h7FFFFFFF, 32'hFFFFFF80, 32'h8000007F, 1'b0, 1'b0, 1'b0);
    add_vec(3'b110, 1'b1, 32'hFFFFFF80, 32'h7FFFFFFF, 32'h7FFFFF81, 1'b0, 1'b0, 1'b0);
    // Logic ops and the reserved encoding.
    add_vec(3'b001, 1'b0, 32'h3FFF2800, 32'h3C031BE0, 32'h3FFF3BE0, 1'b0, 1'b0, 1'b0);
    add_vec(3'b100, 1'b0, 32'h3FFF2800, 32'h3C031BE0, 32'hC000C41F, 1'b0, 1'b0, 1'b0);
    add_vec(3'b101, 1'b0, 32'h3FFF2800, 32'h3C031BE0, 32'h03FC33E0, 1'b0, 1'b0, 1'b0);
    add_vec(3'b000, 1'b0, 32'h3FFF2800, 32'h3C031BE0, 32'h3C030800, 1'b0, 1'b0, 1'b0);
    add_vec(3'b011, 1'b0, 32'h7FFFFFFF, 32'h00000080, 32'h00000000, 1'b0, 1'b0, 1'b0);
    // Comparisons with op = SUB (difference) and op = SLT (zero-extended compout).
    add_vec(3'b110, 1'b0, 32'hFFFFFF80, 32'h00000100, 32'hFFFFFE80, 1'b0, 1'b1, 1'b1);
    add_vec(3'b110, 1'b0, 32'h00000080, 32'hFFFFFF00, 32'h00000180, 1'b0, 1'b1, 1'b0);
    add_vec(3'b110, 1'b0, 32'h00000080, 32'h00000100, 32'hFFFFFF80, 1'b0, 1'b1, 1'b1);
    add_vec(3'b110, 1'b0, 32'hFFFFFF80, 32'hFFFFFF00, 32'h00000080, 1'b0, 1'b1, 1'b0);
    add_vec(3'b110, 1'b1, 32'hFFFFFF80, 32'h00000100, 32'hFFFFFE80, 1'b0, 1'b1, 1'b0);
    add_vec(3'b110, 1'b1, 32'h00000080, 32'hFFFFFF00, 32'h00000180, 1'b0, 1'b1, 1'b1);
    add_vec(3'b110, 1'b1, 32'h00000080, 32'h00000100, 32'hFFFFFF80, 1'b0, 1'b1, 1'b1);
    add_vec(3'b110, 1'b1, 32'hFFFFFF80, 32'hFFFFFF00, 32'h00000080, 1'b0, 1'b1, 1'b0);
    add_vec(3'b111, 1'b0, 32'hFFFFFF80, 32'h00000100, 32'h00000001, 1'b0, 1'b1, 1'b1);
    add_vec(3'b111, 1'b0, 32'h00000080, 32'hFFFFFF00, 32'h00000000, 1'b0, 1'b1, 1'b0);
    add_vec(3'b111, 1'b0, 32'h00000080, 32'h00000100, 32'h00000001, 1'b0, 1'b1, 1'b1);
    add_vec(3'b111, 1'b0, 32'hFFFFFF80, 32'hFFFFFF00, 32'h00000000, 1'b0, 1'b1, 1'b0);
    add_vec(3'b111, 1'b1, 32'hFFFFFF80, 32'h00000100, 32'h00000000, 1'b0, 1'b1, 1'b0);
    add_vec(3'b111, 1'b1, 32'h00000080, 32'hFFFFFF00, 32'h00000001, 1'b0, 1'b1, 1'b1);
    add_vec(3'b111, 1'b1, 32'h00000080, 32'h00000100, 32'h00000001, 1'b0, 1'b1, 1'b1);
    add_vec(3'b111, 1'b1, 32'hFFFFFF80, 32'hFFFFFF00, 32'h00000000, 1'b0, 1'b1, 1'b0);

    // Table vectors change only between edges; the flag is unchecked here.
    foreach (vecs[i]) begin
      @(negedge clock);
      op = vecs[i].op; unsig = vecs[i].unsig; a = vecs[i].a; b = vecs[i].b;
      #1;
      check($sformatf("vec%0d_aluout", i), aluout, vecs[i].exp_out);
      check($sformatf("vec%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].exp_ovf});
      if (vecs[i].chk_comp)
        check($sformatf("vec%0d_comp", i), {31'b0, compout}, {31'b0, vecs[i].exp_comp});
    end

    // Sticky sequence: clear, non-overflow edges, overflow edge, hold, async clear.
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("seq_clear0", {31'b0, ovf_sticky}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    op = 3'b010; unsig = 1'b0; a = 32'h00000100; b = 32'h00000080;
    @(posedge clock); #1;
    check("seq_no_ovf", {31'b0, ovf_sticky}, 32'h0);
    @(negedge clock);
    op = 3'b010; unsig = 1'b1; a = 32'h7FFFFFFF; b = 32'h00000080;
    @(posedge clock); #1;
    check("seq_unsig_no_set", {31'b0, ovf_sticky}, 32'h0);
    @(negedge clock);
    unsig = 1'b0;
    #1;
    check("seq_pre_edge", {31'b0, ovf_sticky}, 32'h0);
    @(posedge clock); #1;
    check("seq_set", {31'b0, ovf_sticky}, 32'h1);
    @(negedge clock);
    op = 3'b000; a = 32'h12345678; b = 32'h0F0F0F0F;
    @(posedge clock); #1;
    check("seq_hold1", {31'b0, ovf_sticky}, 32'h1);
    @(negedge clock);
    op = 3'b110; a = 32'h00000005; b = 32'h00000007;
    @(posedge clock); #1;
    check("seq_hold2", {31'b0, ovf_sticky}, 32'h1);
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("seq_async_clr", {31'b0, ovf_sticky}, 32'h0);
    #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("seq_after_clr", {31'b0, ovf_sticky}, 32'h0);

    // Random stimulus against the reference model, sticky tracked from a fresh reset.
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    m_sticky = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      op    = 3'($urandom_range(0, 7));
      unsig = 1'($urandom_range(0, 1));
      a     = pick_operand();
      b     = pick_operand();
      model(op, unsig, a, b, m_out, m_comp, m_ovf);
      #1;
      check($sformatf("rnd%0d_aluout", k), aluout, m_out);
      check($sformatf("rnd%0d_comp", k), {31'b0, compout}, {31'b0, m_comp});
      check($sformatf("rnd%0d_ovf", k), {31'b0, overflow}, {31'b0, m_ovf});
      @(posedge clock); #1;
      m_sticky = m_sticky | m_ovf;
      check($sformatf("rnd%0d_sticky", k), {31'b0, ovf_sticky}, {31'b0, m_sticky});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
